// File: rtl/parse_unit_if.sv
// Fetch-side bundle input and issue-side decoded instruction output of the
// parse stage, bundled so the stage and its neighbours share one port list.
interface parse_unit_if #(
  parameter int INSTR_WIDTH = 30
);
  logic                     enable_i;
  logic [15:0]              pc_i;
  logic [2*INSTR_WIDTH-1:0] data_i;

  logic                     enable_o;
  logic [15:0]              pc_o;
  logic                     slot_o;
  logic                     format_o;
  logic                     branch_o;
  logic [6:0]               opcode_o;
  logic [4:0]               primReg_o;
  logic [4:0]               secReg_o;
  logic [15:0]              imm_o;

  modport master (
    output enable_i, pc_i, data_i,
    input  enable_o, pc_o, slot_o, format_o, branch_o, opcode_o,
           primReg_o, secReg_o, imm_o
  );

  modport slave (
    input  enable_i, pc_i, data_i,
    output enable_o, pc_o, slot_o, format_o, branch_o, opcode_o,
           primReg_o, secReg_o, imm_o
  );
endinterface

// File: rtl/parse_unit.sv
// Parse stage: buffers two-instruction bundles from fetch, drops NOP slots
// and issues one decoded instruction per cycle toward decode.
module parse_unit #(
  parameter int FIFO_DEPTH  = 4,
  parameter int INSTR_WIDTH = 30
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            flushBack_i,
  input  logic            stall_i,
  output logic            stall_o,
  output logic            overflow_o,
  parse_unit_if.slave     bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ALMOST_C = CW'(FIFO_DEPTH - 1);

  typedef enum logic {SLOT0, SLOT1} slot_state_t;

  logic [15:0]              pc_mem   [FIFO_DEPTH];
  logic [2*INSTR_WIDTH-1:0] data_mem [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_next;
  slot_state_t   state, state_next;

  logic [INSTR_WIDTH-1:0] h0, h1, issue_instr;
  logic push, pop, issue_valid, issue_slot, drop;

  assign h0 = data_mem[rd_ptr][2*INSTR_WIDTH-1:INSTR_WIDTH];
  assign h1 = data_mem[rd_ptr][INSTR_WIDTH-1:0];

  // Slot selection: skip zero slots, stay on a bundle only while slot1 still has work.
  always_comb begin
    pop         = 1'b0;
    issue_valid = 1'b0;
    issue_slot  = 1'b0;
    issue_instr = h0;
    state_next  = state;
    if (flushBack_i) begin
      state_next = SLOT0;
    end else if (!stall_i && count != '0) begin
      case (state)
        SLOT0: begin
          if (h0 != '0) begin
            issue_valid = 1'b1;
            if (h1 != '0) state_next = SLOT1;
            else          pop = 1'b1;
          end else begin
            pop = 1'b1;
            if (h1 != '0) begin
              issue_valid = 1'b1;
              issue_slot  = 1'b1;
              issue_instr = h1;
            end
          end
        end
        SLOT1: begin
          issue_valid = 1'b1;
          issue_slot  = 1'b1;
          issue_instr = h1;
          pop         = 1'b1;
          state_next  = SLOT0;
        end
        default: state_next = SLOT0;
      endcase
    end
  end

  // A full buffer can still accept when the head leaves in the same cycle.
  assign push = bus.enable_i && !flushBack_i && (count != DEPTH_C || pop);
  assign drop = bus.enable_i && !flushBack_i && !push;

  always_comb begin
    count_next = count;
    if (flushBack_i) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) begin
      pc_mem[wr_ptr]   <= bus.pc_i;
      data_mem[wr_ptr] <= bus.data_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state      <= SLOT0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      stall_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      stall_o <= (count_next >= ALMOST_C);
      if (drop) overflow_o <= 1'b1;
      if (flushBack_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Decoded fields only change on a real issue; an idle cycle just clears valid.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      bus.enable_o  <= 1'b0;
      bus.pc_o      <= '0;
      bus.slot_o    <= 1'b0;
      bus.format_o  <= 1'b0;
      bus.branch_o  <= 1'b0;
      bus.opcode_o  <= '0;
      bus.primReg_o <= '0;
      bus.secReg_o  <= '0;
      bus.imm_o     <= '0;
    end else if (flushBack_i) begin
      bus.enable_o <= 1'b0;
    end else if (!stall_i) begin
      bus.enable_o <= issue_valid;
      if (issue_valid) begin
        bus.pc_o      <= pc_mem[rd_ptr];
        bus.slot_o    <= issue_slot;
        bus.format_o  <= issue_instr[29];
        bus.branch_o  <= issue_instr[28];
        bus.opcode_o  <= issue_instr[27:21];
        bus.primReg_o <= issue_instr[20:16];
        bus.secReg_o  <= issue_instr[29] ? 5'd0 : issue_instr[15:11];
        bus.imm_o     <= issue_instr[29] ? issue_instr[15:0] : 16'd0;
      end
    end
  end

endmodule

// File: doc/parse_unit.md
Name: parse_unit

Overview:
- Stage 1, directly downstream of instruction fetch.
- Accepts 60-bit two-instruction bundles with their PC and buffers them in a small FIFO.
- Splits each bundle into its two 30-bit instructions and issues one decoded instruction per cycle to decode/dependency logic.
- Drops all-zero NOP slots and raises stall_o toward fetch before the buffer overflows.

Parameters:
- FIFO_DEPTH, 4: bundle buffer entries (power of 2, >=2).
- INSTR_WIDTH, 30: bits per instruction slot; bundle width is 2*INSTR_WIDTH.

Ports:
- clock_i  in  1  rising-edge clock.
- reset_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  bundle valid from fetch.
- pc_i  in  16  bundle PC from fetch.
- data_i  in  60  bundle; [59:30] slot0 (older), [29:0] slot1.
- flushBack_i  in  1  pipeline flush.
- stall_i  in  1  downstream hold; outputs freeze, nothing issues.
- stall_o  out  1  to fetch: buffer almost full.
- overflow_o  out  1  sticky: bundle dropped because buffer was full.
- enable_o  out  1  issued instruction valid.
- pc_o  out  16  PC of the issued instruction's bundle.
- slot_o  out  1  0 = slot0, 1 = slot1.
- format_o  out  1  instr[29]; 1 = reg-imm, 0 = reg-reg.
- branch_o  out  1  instr[28].
- opcode_o  out  7  instr[27:21].
- primReg_o  out  5  instr[20:16].
- secReg_o  out  5  instr[15:11] when format=0, else 0.
- imm_o  out  16  instr[15:0] when format=1, else 0.

Behaviour:
- Reset (reset_i=0, async): FIFO empty; slot pointer 0; all outputs 0, including overflow_o and stall_o.
- Push: on a clock edge with enable_i=1 and flushBack_i=0, {pc_i, data_i} is written if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop occurs in the same cycle. Otherwise the bundle is dropped and overflow_o is set to 1 until reset.
- stall_o: registered; 1 when count >= FIFO_DEPTH-1, covering the one in-flight bundle from the registered fetch.
- NOP: a 30-bit slot equal to 0 is never issued.
- Issue: evaluated each edge when stall_i=0 and FIFO is non-empty. The head bundle is H, with slot halves H0/H1.
  - ptr=0, H0!=0: issue H0 (slot_o=0). If H1!=0, set ptr=1; otherwise pop.
  - ptr=0, H0==0, H1!=0: issue H1 (slot_o=1) and pop.
  - ptr=0, H0==0, H1==0: pop; enable_o=0.
  - ptr=1: issue H1, pop, set ptr=0.
  - FIFO empty and stall_i=0: enable_o=0; other outputs hold.
- stall_i=1: all outputs, ptr and FIFO head hold. Pushes still accepted.
- Latency: a bundle pushed at edge N can issue at edge N+1 at the earliest. Maximum throughput is 1 instruction per cycle.
- Flush (flushBack_i=1, synchronous, highest priority after reset): FIFO emptied, ptr=0, enable_o=0, stall_o=0. The same-cycle enable_i bundle is discarded. overflow_o is unchanged.
- Reset asserted mid-issue: immediate return to the reset state. A partially issued bundle is lost.
- Pointers: read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits. Simultaneous push and pop leaves count unchanged.

Test Plan:
- Dual issue:
  - Stimulus: pc_i=1, data_i={1_0_0001010_00001_0000000000000101, 1_0_0001010_00010_0000000000001010}, one cycle.
  - Edge+1: enable_o=1, slot_o=0, opcode_o=0x0A, primReg_o=1, imm_o=5, pc_o=1.
  - Edge+2: slot_o=1, primReg_o=2, imm_o=10.
  - Edge+3: enable_o=0.
- NOP skip:
  - Stimulus: pc_i=3, data_i={0_0_0000010_00001_00010_00000000000, 30'b0}.
  - Response: one issue, format_o=0, opcode_o=2, primReg_o=1, secReg_o=2, imm_o=0. The next cycle is empty.
  - Stimulus: all-zero bundle.
  - Response: enable_o never asserts.
- Backpressure/overflow:
  - Stimulus: stall_i=1, six consecutive dual-issue bundles.
  - Response: stall_o=1 after the 3rd push; the 5th and 6th bundles are dropped; overflow_o=1.
  - Release stall_i.
  - Response: exactly 8 instructions issue, in PC order.
- Stall hold:
  - Stimulus: raise stall_i while slot0 of a bundle is presented.
  - Response: outputs hold for every stalled cycle. slot1 issues on the first edge after stall_i falls.
- Flush:
  - Stimulus: two bundles buffered, then flushBack_i=1 together with enable_i=1.
  - Response: next edge enable_o=0 and the FIFO is empty. The following bundle issues normally with slot_o=0.
- Async reset:
  - Stimulus: drive reset_i low between clock edges during slot1 issue.
  - Response: enable_o and overflow_o are 0 immediately, without waiting for a clock edge.
